// File: rtl/alu_seq_pkg.sv
// Shared types and default widths for the ALU command sequencer.
// The state encoding is visible to the top-level FSM only.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    localparam int CMD_W_DEF  = 12;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with occupancy count and async active-low reset.
// Pushes while full and pops while empty are ignored.
module cmd_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     wr_data,
    input  logic             pop,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the ALU controller: queues host commands, issues one at a
// time with a run strobe, and returns the response or a timeout result.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CMD_W   = CMD_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CMD_W-1:0]         cmd_in,
    input  logic                     cmd_in_valid,
    output logic                     cmd_in_ready,
    output logic [CMD_W-1:0]         command,
    output logic                     run,
    input  logic                     resp_valid,
    input  logic [DATA_W-1:0]        resp_y,
    input  logic                     resp_z,
    output logic [DATA_W-1:0]        res_y,
    output logic                     res_z,
    output logic                     res_timeout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    seq_state_t      state;
    logic [TW-1:0]   to_cnt;
    logic [CMD_W-1:0] fifo_rd;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    // Ready depends on occupancy only; a same-cycle pop does not free a slot.
    assign cmd_in_ready = !fifo_full;
    assign push         = cmd_in_valid && cmd_in_ready;
    assign pop          = (state == IDLE) && !fifo_empty;
    assign busy         = (state != IDLE) || !fifo_empty;

    cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            command     <= '0;
            run         <= 1'b0;
            to_cnt      <= '0;
            res_y       <= '0;
            res_z       <= 1'b0;
            res_timeout <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        command <= fifo_rd;
                        run     <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    run    <= 1'b0;
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // A real response takes priority over the terminal count.
                    if (resp_valid) begin
                        res_y       <= resp_y;
                        res_z       <= resp_z;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= HOLD;
                    end else if (to_cnt == TO_LAST) begin
                        res_y       <= '0;
                        res_z       <= 1'b0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: issue, backpressure, timeout,
// coincident events, mid-operation reset and FIFO pointer wrap.
module tb_alu_cmd_sequencer;

    localparam int CMD_W   = 12;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CMD_W-1:0]  cmd_in = '0;
    logic              cmd_in_valid = 1'b0;
    logic              cmd_in_ready;
    logic [CMD_W-1:0]  command;
    logic              run;
    logic              resp_valid = 1'b0;
    logic [DATA_W-1:0] resp_y = '0;
    logic              resp_z = 1'b0;
    logic [DATA_W-1:0] res_y;
    logic              res_z;
    logic              res_timeout;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              busy;
    logic [3:0]        fifo_count;

    int n_pass  = 0;
    int n_total = 0;

    alu_cmd_sequencer #(
        .CMD_W(CMD_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_in(cmd_in), .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready),
        .command(command), .run(run),
        .resp_valid(resp_valid), .resp_y(resp_y), .resp_z(resp_z),
        .res_y(res_y), .res_z(res_z), .res_timeout(res_timeout),
        .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [CMD_W-1:0] c);
        cmd_in       = c;
        cmd_in_valid = 1'b1;
        step();
        cmd_in_valid = 1'b0;
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (run) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic respond(input logic [DATA_W-1:0] y, input logic z);
        resp_valid = 1'b1;
        resp_y     = y;
        resp_z     = z;
        step();
        resp_valid = 1'b0;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total++; if (cmd_in_ready !== 1'b1) $display("FAIL reset_ready act=%0b exp=1", cmd_in_ready); else n_pass++;
        n_total++; if (run !== 1'b0) $display("FAIL reset_run act=%0b exp=0", run); else n_pass++;
        n_total++; if (command !== 12'h000) $display("FAIL reset_command act=%h exp=000", command); else n_pass++;
        n_total++; if (res_valid !== 1'b0 || res_timeout !== 1'b0 || res_y !== 32'h0 || res_z !== 1'b0)
            $display("FAIL reset_result act=v%0b t%0b y%h z%0b exp=all0", res_valid, res_timeout, res_y, res_z); else n_pass++;
        n_total++; if (busy !== 1'b0 || fifo_count !== 4'd0)
            $display("FAIL reset_busy_count act=busy%0b cnt%0d exp=0/0", busy, fifo_count); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        push_cmd(12'h0A5);
        n_total++; if (run !== 1'b0) $display("FAIL basic_latency act=%0b exp=0", run); else n_pass++;
        step();
        n_total++; if (run !== 1'b1) $display("FAIL basic_run_rise act=%0b exp=1", run); else n_pass++;
        wait_run(ok);
        n_total++; if (!ok) $display("FAIL basic_run_seen act=0 exp=1"); else n_pass++;
        n_total++; if (command !== 12'h0A5) $display("FAIL basic_command act=%h exp=0a5", command); else n_pass++;
        step();
        n_total++; if (run !== 1'b0) $display("FAIL basic_run_one_cycle act=%0b exp=0", run); else n_pass++;
        step(); step();
        respond(32'h0000_0010, 1'b0);
        n_total++; if (res_valid !== 1'b1 || res_y !== 32'h10 || res_timeout !== 1'b0 || res_z !== 1'b0)
            $display("FAIL basic_result act=v%0b y%h t%0b z%0b exp=v1 y00000010 t0 z0", res_valid, res_y, res_timeout, res_z); else n_pass++;
        step(); step();
        n_total++; if (res_valid !== 1'b1 || res_y !== 32'h10) $display("FAIL basic_hold act=v%0b y%h exp=v1 y00000010", res_valid, res_y); else n_pass++;
        n_total++; if (command !== 12'h0A5) $display("FAIL basic_command_hold act=%h exp=0a5", command); else n_pass++;
        accept();
        n_total++; if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_release act=v%0b busy%0b exp=0/0", res_valid, busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        push_cmd(12'h100);
        wait_run(ok);
        step();
        respond(32'h100, 1'b0);
        // Sequencer is parked in HOLD; the FIFO fills without draining.
        for (int i = 0; i < 9; i++) begin
            cmd_in       = 12'h101 + 12'(i);
            cmd_in_valid = 1'b1;
            if (i == 8) begin
                n_total++; if (cmd_in_ready !== 1'b0) $display("FAIL full_ready act=%0b exp=0", cmd_in_ready); else n_pass++;
                n_total++; if (fifo_count !== 4'd8) $display("FAIL full_count act=%0d exp=8", fifo_count); else n_pass++;
            end
            step();
        end
        cmd_in_valid = 1'b0;
        n_total++; if (fifo_count !== 4'd8) $display("FAIL full_refused act=%0d exp=8", fifo_count); else n_pass++;
        accept();
        for (int i = 0; i < 8; i++) begin
            wait_run(ok);
            n_total++; if (!ok || command !== 12'h101 + 12'(i))
                $display("FAIL order_cmd%0d act=%h ok%0b exp=%h", i, command, ok, 12'h101 + 12'(i)); else n_pass++;
            step();
            respond(32'h5000 + 32'(i), 1'b0);
            n_total++; if (res_valid !== 1'b1 || res_y !== 32'h5000 + 32'(i))
                $display("FAIL order_res%0d act=v%0b y%h exp=%h", i, res_valid, res_y, 32'h5000 + 32'(i)); else n_pass++;
            accept();
        end
        n_total++; if (busy !== 1'b0 || cmd_in_ready !== 1'b1) $display("FAIL drain_idle act=busy%0b rdy%0b exp=0/1", busy, cmd_in_ready); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        push_cmd(12'h0C3);
        wait_run(ok);
        n_total++; if (!ok || command !== 12'h0C3) $display("FAIL to_cmd act=%h exp=0c3", command); else n_pass++;
        for (int i = 0; i < TIMEOUT; i++) step();
        n_total++; if (res_valid !== 1'b0) $display("FAIL to_early act=%0b exp=0", res_valid); else n_pass++;
        step();
        n_total++; if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_y !== 32'h0 || res_z !== 1'b0)
            $display("FAIL to_result act=v%0b t%0b y%h z%0b exp=v1 t1 y0 z0", res_valid, res_timeout, res_y, res_z); else n_pass++;
        accept();
        push_cmd(12'h0C4);
        wait_run(ok);
        n_total++; if (!ok || command !== 12'h0C4) $display("FAIL to_next_cmd act=%h exp=0c4", command); else n_pass++;
        step();
        respond(32'h77, 1'b0);
        n_total++; if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_y !== 32'h77)
            $display("FAIL to_next_res act=v%0b t%0b y%h exp=v1 t0 y77", res_valid, res_timeout, res_y); else n_pass++;
        accept();
    endtask

    task automatic test_coincident();
        bit ok;
        push_cmd(12'h0D1);
        wait_run(ok);
        respond(32'hDEAD, 1'b1);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        n_total++; if (res_valid !== 1'b0) $display("FAIL coin_run_early act=%0b exp=0", res_valid); else n_pass++;
        step();
        n_total++; if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_y !== 32'h0)
            $display("FAIL coin_run_dropped act=v%0b t%0b y%h exp=v1 t1 y0", res_valid, res_timeout, res_y); else n_pass++;
        accept();
        push_cmd(12'h0D2);
        wait_run(ok);
        for (int i = 0; i < TIMEOUT; i++) step();
        n_total++; if (res_valid !== 1'b0) $display("FAIL coin_last_early act=%0b exp=0", res_valid); else n_pass++;
        respond(32'h0, 1'b1);
        n_total++; if (res_valid !== 1'b1 || res_timeout !== 1'b0 || res_z !== 1'b1 || res_y !== 32'h0)
            $display("FAIL coin_last_wins act=v%0b t%0b z%0b y%h exp=v1 t0 z1 y0", res_valid, res_timeout, res_z, res_y); else n_pass++;
        accept();
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int i = 0; i < 4; i++) push_cmd(12'h300 + 12'(i));
        n_total++; if (fifo_count !== 4'd3 || busy !== 1'b1) $display("FAIL mid_pre act=cnt%0d busy%0b exp=3/1", fifo_count, busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (run !== 1'b0 || fifo_count !== 4'd0 || res_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset act=run%0b cnt%0d v%0b busy%0b exp=0", run, fifo_count, res_valid, busy); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        n_total++; if (busy !== 1'b0 || command !== 12'h000 || cmd_in_ready !== 1'b1)
            $display("FAIL mid_release act=busy%0b cmd%h rdy%0b exp=0/000/1", busy, command, cmd_in_ready); else n_pass++;
        push_cmd(12'h3AA);
        wait_run(ok);
        rst_n = 1'b0;
        #1;
        n_total++; if (!ok || run !== 1'b0) $display("FAIL issue_reset_run act=%0b ok%0b exp=0", run, ok); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < 20; i++) begin
            push_cmd(12'h200 + 12'(i));
            wait_run(ok);
            n_total++; if (!ok || command !== 12'h200 + 12'(i))
                $display("FAIL wrap_cmd%0d act=%h ok%0b exp=%h", i, command, ok, 12'h200 + 12'(i)); else n_pass++;
            step();
            respond(32'(i), 1'b0);
            accept();
        end
        n_total++; if (fifo_count !== 4'd0 || busy !== 1'b0) $display("FAIL wrap_end act=cnt%0d busy%0b exp=0/0", fifo_count, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_coincident();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the ALU controller command interface.
- Buffers 12-bit commands pushed by a host and issues them one at a time as command plus a one-cycle run strobe.
- Waits for the controller's response (result y and zero flag) and presents it to the host on a valid/ready result port.
- Enforces a response timeout so a hung controller cannot stall the host.

Parameters:
- CMD_W, 12, command word width (matches controller command input)
- DATA_W, 32, result width (matches ALU y)
- DEPTH, 8, command FIFO entries (power of two, >=2)
- TIMEOUT, 16, max cycles to wait for a response after run (>=2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_in  input  CMD_W  host command word
- cmd_in_valid  input  1  host offers cmd_in
- cmd_in_ready  output  1  FIFO can accept a word
- command  output  CMD_W  command to controller
- run  output  1  one-cycle issue strobe to controller
- resp_valid  input  1  controller result valid (one-cycle pulse)
- resp_y  input  DATA_W  controller result
- resp_z  input  1  controller zero flag
- res_y  output  DATA_W  held result to host
- res_z  output  1  held zero flag
- res_timeout  output  1  result produced by timeout, not by the controller
- res_valid  output  1  result available
- res_ready  input  1  host accepts result
- busy  output  1  FSM not IDLE or FIFO non-empty
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0 except cmd_in_ready=1.
  - FIFO emptied, state IDLE.
  - run drops immediately on reset assertion, even mid-transaction; any in-flight command is discarded.
- FIFO:
  - Push on cmd_in_valid && cmd_in_ready.
  - cmd_in_ready = (fifo_count < DEPTH); it depends on count only, so a push is refused when full even in a cycle where a pop occurs.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full leaves the count unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if fifo_count>0, pop head into the command register and go to ISSUE; otherwise stay.
  - ISSUE: run=1 for exactly this cycle, then go to WAIT and clear the timeout counter.
  - WAIT:
    - If resp_valid: capture resp_y/resp_z, set res_timeout=0, go to HOLD.
    - Else if counter==TIMEOUT-1: set res_y=0, res_z=0, res_timeout=1, go to HOLD.
    - Else: increment counter.
  - HOLD: res_valid=1 with res_y/res_z/res_timeout stable until res_ready; on res_valid&&res_ready go to IDLE.
- Latency: push accepted at edge k; run high in the cycle after edge k+1.
- The command output holds its value from the pop until the next pop. Default 0 after reset.
- resp_valid is ignored in IDLE, ISSUE and HOLD. A response in the same cycle as run is dropped.
- If resp_valid and the timeout condition coincide, the response wins (res_timeout=0).
- The IDLE->ISSUE bubble is mandatory: the minimum issue-to-issue spacing is 4 cycles.

Decomposition:
- Package alu_seq_pkg:
  - seq_state_t enum {IDLE, ISSUE, WAIT, HOLD}.
  - Default CMD_W/DATA_W constants.
- Sub-module cmd_fifo: parameterised synchronous FIFO with push/pop, count, full/empty, and async active-low reset.
- The FSM, timeout counter and result registers stay in alu_cmd_sequencer.

Test Plan:
- Basic issue: push 12'h0A5. Expect:
  - run=1 for exactly 1 cycle, command=12'h0A5.
  - Drive resp_valid 3 cycles later with y=32'h0000_0010, z=0.
  - Result: res_valid=1, res_y=32'h10, res_timeout=0; holds until res_ready.
- Backpressure and full FIFO:
  - Hold res_ready=0 and push 9 commands.
  - Expect cmd_in_ready=0 once fifo_count=8, with the 9th push refused.
  - After releasing res_ready and answering each issued command, the commands issue in order.
- Timeout:
  - Issue a command with no resp_valid.
  - Expect res_valid with res_timeout=1 and res_y=0 exactly TIMEOUT cycles after run.
  - The next command then issues normally.
- Coincident events:
  - Assert resp_valid in the run cycle: it is ignored, and the transaction ends by timeout.
  - Assert resp_valid at counter=TIMEOUT-1: res_timeout=0 and the data is captured.
- Reset mid-operation:
  - Assert rst_n=0 during WAIT with 3 commands queued.
  - Expect run=0 immediately, fifo_count=0, res_valid=0, and busy=0 after release.
- Wrap-around: push and drain 20 commands at 1 per transaction. Expect commands delivered in order with no loss across pointer wrap.
